ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, byte-address width of the RAMIO port A address.
REQ-002 Parameter DATA_WIDTH, default 32, data width of the RAMIO port A data.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester request; bit i = requester i.
REQ-006 req_we  in  4  write size per requester, bits [2i+1:2i]: 01 byte, 10 half, 11 word, 00 none.
REQ-007 req_re  in  6  read code per requester, bits [3i+2:3i]: bit2 sign-extend, bits[1:0] size as req_we.
REQ-008 req_addr  in  2*ADDR_WIDTH  byte address per requester.
REQ-009 req_din  in  2*DATA_WIDTH  write data per requester, right-aligned.
REQ-010 req_ready  out  2  one-cycle accept pulse to requester i.
REQ-011 rsp_valid  out  2  one-cycle completion pulse to requester i.
REQ-012 rsp_data  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes.
REQ-013 rsp_err  out  1  misaligned-access flag, valid with rsp_valid.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 ram_we  out  2, ram_re  out  3, ram_addr  out  ADDR_WIDTH, ram_din  out  DATA_WIDTH: drive RAMIO weA/reA/addrA/dinA.
REQ-016 ram_dout  in  DATA_WIDTH  from RAMIO doutA, valid the cycle after the strobe.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req_valid is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-018 In IDLE with a request: select winner, pulse req_ready[winner] that cycle, register winner's we/re/addr/din at the edge.
REQ-019 Requester holds valid and payload stable until req_ready; deasserting valid before req_ready withdraws the request with no effect.
REQ-020 In ACCESS: drive ram_we/ram_re/ram_addr/ram_din from the registered command for exactly one cycle; ram_we and ram_re are 0 in all other cycles.
REQ-021 In RESP: pulse rsp_valid[winner]; rsp_data = ram_dout for reads, 0 for writes; response arrives 2 cycles after the req_ready cycle.
REQ-022 Throughput: at most one transaction per 3 cycles; no pipelining.
REQ-023 we and re both nonzero: write wins, ram_re driven 0.
REQ-024 we and re both zero: accepted, no RAM strobe, response with rsp_data 0, rsp_err 0.
REQ-025 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no RAM strobe in ACCESS, response with rsp_err 1, rsp_data 0.
REQ-026 rsp_err is 0 whenever rsp_valid is 0.
REQ-027 Requests arriving during ACCESS/RESP wait; req_ready never asserts outside IDLE.

Reset
REQ-028 rst_n low forces IDLE asynchronously; req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_we, ram_re, ram_addr, ram_din all 0.
REQ-029 Reset mid-transaction discards it: no RAM strobe, no response delivered after rst_n rises.
REQ-030 Priority pointer resets to requester 0 preferred.

Configuration
REQ-031 Macro RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted last; pointer updates on each grant.
REQ-032 Macro undefined: fixed priority, requester 0 always wins ties; no pointer state.

Verification
REQ-033 Requester 0 word write 0xFFFEFDFC @8 -> req_ready[0] cycle k, ram_we=11 cycle k+1, rsp_valid[0] cycle k+2, rsp_data 0; then signed byte read @11 -> rsp_data 0xFFFFFFFF.
REQ-034 Both requesters read @0 every IDLE after reset -> RR: grants 0,1,0,1; fixed: 0,0,0,0.
REQ-035 Half read @5 from requester 1 -> no ram_re strobe, rsp_valid[1] with rsp_err 1, rsp_data 0.
REQ-036 Requester 0 drives we=01, re=111 -> byte write issued, ram_re 0, rsp_data 0.
REQ-037 rst_n pulsed low during ACCESS -> all outputs 0 immediately, no rsp_valid afterwards, next grant goes to requester 0.
REQ-038 Requester 1 withdraws valid while requester 0 holds the grant -> requester 1 never receives req_ready or rsp_valid.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester arbiter in front of the RAMIO port A.
// One transaction at a time through IDLE -> ACCESS -> RESP. The RAM strobe
// lasts only for the ACCESS cycle, and the response pulses in RESP.
// Optional build macro RAM_ARB_ROUND_ROBIN_EN: on simultaneous requests,
// alternate between requesters. When it is undefined, requester 0 wins ties.

// Per-requester command decode: applies write-wins, drops empty read codes
// and suppresses strobes for misaligned accesses.
module ram_port_arbiter_lane (
  input  logic [1:0] we,
  input  logic [2:0] re,
  input  logic [1:0] addrLo,
  output logic [1:0] effWe,
  output logic [2:0] effRe,
  output logic       misaligned
);
  logic [1:0] size;

  // A write decides the access size when present; otherwise the read code does
  always_comb begin
    size       = (we != 2'b00) ? we : re[1:0];
    misaligned = ((size == 2'b10) && addrLo[0]) ||
                 ((size == 2'b11) && (addrLo != 2'b00));
    effWe      = misaligned ? 2'b00 : we;
    effRe      = (misaligned || (we != 2'b00) || (re[1:0] == 2'b00)) ? 3'b000 : re;
  end
endmodule

module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [3:0]              req_we,
  input  logic [5:0]              req_re,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_din,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [1:0]              ram_we,
  output logic [2:0]              ram_re,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);
  localparam int NUM_REQ = 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] RESP   = 2'b10;

  logic [1:0] state, stateNext;

  logic [NUM_REQ-1:0][1:0]            laneWe;
  logic [NUM_REQ-1:0][2:0]            laneRe;
  logic [NUM_REQ-1:0]                 laneMis;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] laneAddr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] laneDin;

  logic winner;
  logic grant;

  // Registered command of the transaction in flight
  logic                  cmdWin;
  logic [1:0]            cmdWe;
  logic [2:0]            cmdRe;
  logic [ADDR_WIDTH-1:0] cmdAddr;
  logic [DATA_WIDTH-1:0] cmdDin;
  logic                  cmdErr;

  // Split the flat request buses into per-requester lanes and decode each
  for (genvar i = 0; i < NUM_REQ; i++) begin : gLane
    assign laneAddr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign laneDin[i]  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
    ram_port_arbiter_lane uLane (
      .we        (req_we[2*i +: 2]),
      .re        (req_re[3*i +: 3]),
      .addrLo    (laneAddr[i][1:0]),
      .effWe     (laneWe[i]),
      .effRe     (laneRe[i]),
      .misaligned(laneMis[i])
    );
  end

  // A grant happens only in IDLE and never while reset is held
  assign grant = rst_n && (state == IDLE) && (req_valid != 2'b00);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Requester to prefer on the next tie; starts at requester 0
  logic prefer;

  // On a tie, pick the preferred requester; otherwise pick the one that is asking
  always_comb winner = (req_valid == 2'b11) ? prefer : ~req_valid[0];

  // After each grant, hand preference to the requester that did not win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     prefer <= 1'b0;
    else if (grant) prefer <= ~winner;
  end
`else
  // Fixed priority: requester 0 wins whenever it asks
  always_comb winner = ~req_valid[0];
`endif

  // Accept pulse goes to the winner during the grant cycle only
  always_comb begin
    req_ready = 2'b00;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Three-state sequence; a grant is the only way out of IDLE
  always_comb begin
    stateNext = IDLE;
    case (state)
      IDLE:    stateNext = grant ? ACCESS : IDLE;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register; reset discards any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Latch the winner's decoded command on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdWin  <= 1'b0;
      cmdWe   <= 2'b00;
      cmdRe   <= 3'b000;
      cmdAddr <= '0;
      cmdDin  <= '0;
      cmdErr  <= 1'b0;
    end else if (grant) begin
      cmdWin  <= winner;
      cmdWe   <= laneWe[winner];
      cmdRe   <= laneRe[winner];
      cmdAddr <= laneAddr[winner];
      cmdDin  <= laneDin[winner];
      cmdErr  <= laneMis[winner];
    end
  end

  // Drive the RAM port during ACCESS only, and keep it at zero in every other cycle
  always_comb begin
    ram_we   = 2'b00;
    ram_re   = 3'b000;
    ram_addr = '0;
    ram_din  = '0;
    if (state == ACCESS) begin
      ram_we   = cmdWe;
      ram_re   = cmdRe;
      ram_addr = cmdAddr;
      ram_din  = cmdDin;
    end
  end

  // Response in RESP. Read data is forwarded only when a read strobe was issued
  always_comb begin
    rsp_valid = 2'b00;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (state == RESP) begin
      rsp_valid[cmdWin] = 1'b1;
      rsp_err           = cmdErr;
      if (cmdRe != 3'b000) rsp_data = ram_dout;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter. A byte-wide RAMIO model sits on port A.
// Expected responses go into a queue as each request is accepted. A monitor
// pops an entry and compares it whenever the design produces a response.
module tb_ram_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid;
  logic [3:0]      req_we;
  logic [5:0]      req_re;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_din;
  logic [1:0]      req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err, busy;
  logic [1:0]      ram_we;
  logic [2:0]      ram_re;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout = '0;

  int nTests = 0;
  int nFail  = 0;
  int weStrobes = 0;

  typedef struct packed {
    logic          who;
    logic [DW-1:0] data;
    logic          err;
  } rspExp_t;

  rspExp_t expQ[$];

  logic [7:0] mem [256] = '{default: 8'h00};

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_re(req_re),
    .req_addr(req_addr), .req_din(req_din), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  function automatic logic [31:0] ramRead(input logic [2:0] re, input logic [7:0] a);
    logic [31:0] w;
    w = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    case (re[1:0])
      2'b01:   return re[2] ? {{24{w[7]}}, w[7:0]} : {24'b0, w[7:0]};
      2'b10:   return re[2] ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // RAMIO port A model: little-endian byte RAM; read data appears on the cycle after the strobe
  always @(posedge clk) begin
    if (ram_we != 2'b00) begin
      mem[ram_addr[7:0]] <= ram_din[7:0];
      if (ram_we[1]) mem[ram_addr[7:0]+8'd1] <= ram_din[15:8];
      if (ram_we == 2'b11) begin
        mem[ram_addr[7:0]+8'd2] <= ram_din[23:16];
        mem[ram_addr[7:0]+8'd3] <= ram_din[31:24];
      end
      weStrobes <= weStrobes + 1;
    end
    if (ram_re != 3'b000) ram_dout <= ramRead(ram_re, ram_addr[7:0]);
    else                  ram_dout <= 32'hDEADBEEF;
  end

  // Response monitor plus protocol invariants
  always @(negedge clk) begin
    rspExp_t e;
    if (rst_n) begin
      if (rsp_valid != 2'b00) begin
        if (expQ.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 2'b00);
        end else begin
          e = expQ.pop_front();
          chk("rsp_who", rsp_valid, 2'b01 << e.who);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
        end
      end else if (rsp_err) begin
        chk("rsp_err_idle", rsp_err, 1'b0);
      end
      if (busy && req_ready != 2'b00) chk("ready_busy", req_ready, 2'b00);
    end
  end

  task automatic doReset();
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single request from one requester, with checks for strobe timing and content
  task automatic issue(input int who, input logic [1:0] we, input logic [2:0] re,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din,
                       input logic [1:0] eWe, input logic [2:0] eRe,
                       input logic [DW-1:0] eData, input logic eErr);
    int n;
    rspExp_t e;
    @(negedge clk);
    req_we[2*who +: 2]    = we;
    req_re[3*who +: 3]    = re;
    req_addr[AW*who +: AW] = addr;
    req_din[DW*who +: DW] = din;
    req_valid[who]        = 1'b1;
    #1;
    n = 0;
    while (!req_ready[who] && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", req_ready[who], 1'b1);
    if (!req_ready[who]) begin
      req_valid[who] = 1'b0;
      return;
    end
    e.who = who[0]; e.data = eData; e.err = eErr;
    expQ.push_back(e);
    @(negedge clk);
    req_valid[who] = 1'b0;
    #1;
    chk("ram_we", ram_we, eWe);
    chk("ram_re", ram_re, eRe);
    if (eWe != 2'b00 || eRe != 3'b000) chk("ram_addr", ram_addr, addr);
    if (eWe != 2'b00) chk("ram_din", ram_din, din);
    @(negedge clk); #1;
    chk("rsp_timing", rsp_valid, 2'b01 << who);
  endtask

  // Both requesters read word @0 in every IDLE; bit g of expWin is the expected winner of grant g
  task automatic grantSeq(input int n, input logic [3:0] expWin);
    int got = 0;
    int cyc = 0;
    rspExp_t e;
    @(negedge clk);
    req_we = 4'b0; req_re = 6'b011_011; req_addr = '0; req_valid = 2'b11;
    while (got < n && cyc < 30) begin
      #1;
      if (req_ready != 2'b00) begin
        chk($sformatf("grant%0d", got), req_ready, 2'b01 << expWin[got]);
        e.who = expWin[got]; e.data = 32'h11223344; e.err = 1'b0;
        expQ.push_back(e);
        got++;
      end
      @(negedge clk); cyc++;
    end
    req_valid = 2'b00;
    chk("grant_count", got, n);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int wb;
    rspExp_t e;
    req_valid = 2'b11; req_we = '0; req_re = '0; req_addr = '0; req_din = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_we, ram_re, ram_addr, ram_din}, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Word write followed by reads of several sizes and signedness
    issue(0, 2'b11, 3'b000, 15'd8, 32'hFFFEFDFC, 2'b11, 3'b000, 32'h0, 1'b0);
    issue(0, 2'b00, 3'b101, 15'd11, 32'h0, 2'b00, 3'b101, 32'hFFFFFFFF, 1'b0);
    issue(1, 2'b00, 3'b001, 15'd9, 32'h0, 2'b00, 3'b001, 32'h000000FD, 1'b0);
    issue(1, 2'b00, 3'b110, 15'd10, 32'h0, 2'b00, 3'b110, 32'hFFFFFFFE, 1'b0);
    issue(0, 2'b00, 3'b011, 15'd8, 32'h0, 2'b00, 3'b011, 32'hFFFEFDFC, 1'b0);
    // Misaligned accesses: no strobe, error response
    issue(1, 2'b00, 3'b010, 15'd5, 32'h0, 2'b00, 3'b000, 32'h0, 1'b1);
    issue(0, 2'b11, 3'b000, 15'd6, 32'h55555555, 2'b00, 3'b000, 32'h0, 1'b1);
    // Write wins over a simultaneous read code
    issue(0, 2'b01, 3'b111, 15'd20, 32'h123456A5, 2'b01, 3'b000, 32'h0, 1'b0);
    issue(1, 2'b00, 3'b001, 15'd20, 32'h0, 2'b00, 3'b001, 32'h000000A5, 1'b0);
    issue(1, 2'b00, 3'b101, 15'd20, 32'h0, 2'b00, 3'b101, 32'hFFFFFFA5, 1'b0);
    // Empty command: accepted, no strobe, zero response
    issue(1, 2'b00, 3'b000, 15'd3, 32'h0, 2'b00, 3'b000, 32'h0, 1'b0);
    // Aligned half write, then a word read back
    issue(1, 2'b10, 3'b000, 15'd16, 32'h9999BEEF, 2'b10, 3'b000, 32'h0, 1'b0);
    issue(0, 2'b00, 3'b011, 15'd16, 32'h0, 2'b00, 3'b011, 32'h0000BEEF, 1'b0);
    issue(0, 2'b11, 3'b000, 15'd0, 32'h11223344, 2'b11, 3'b000, 32'h0, 1'b0);

    // Tie arbitration right after reset
    doReset();
`ifdef RAM_ARB_ROUND_ROBIN_EN
    grantSeq(4, 4'b1010);
`else
    grantSeq(4, 4'b0000);
`endif

    // Reset asserted during ACCESS
    @(negedge clk);
    req_we[1:0] = 2'b11; req_re[2:0] = 3'b000; req_addr[AW-1:0] = 15'd40;
    req_din[DW-1:0] = 32'hCAFEF00D; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_grant", req_ready[0], 1'b1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk("rst_access_we", ram_we, 2'b11);
    wb = weStrobes;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy, ram_we, ram_re, ram_addr, ram_din}, 0);
    @(negedge clk);
    chk("rst_no_strobe", weStrobes, wb);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_no_rsp", rsp_valid, 2'b00);
    end
    grantSeq(1, 4'b0000);
    issue(0, 2'b00, 3'b011, 15'd40, 32'h0, 2'b00, 3'b011, 32'h0, 1'b0);

    // Requester 1 raises valid and withdraws it while requester 0 owns the port
    @(negedge clk);
    req_we[1:0] = 2'b00; req_re[2:0] = 3'b011; req_addr[AW-1:0] = 15'd8; req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("wd_grant0", req_ready, 2'b01);
    e.who = 1'b0; e.data = 32'hFFFEFDFC; e.err = 1'b0;
    expQ.push_back(e);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_we[3:2] = 2'b11; req_re[5:3] = 3'b000; req_addr[2*AW-1:AW] = 15'd12;
    req_din[2*DW-1:DW] = 32'hBAD0BAD0; req_valid[1] = 1'b1;
    #1;
    chk("wd_ready_access", req_ready, 2'b00);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("wd_no_ready", req_ready, 2'b00);
    end
    issue(0, 2'b00, 3'b011, 15'd12, 32'h0, 2'b00, 3'b011, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("drain", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
